// File: rtl/serial_adder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | serial_adder_pkg                                                     |
// | Shared state type and default sizing for the chunked serial adder.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package serial_adder_pkg;

  // Operation sequencing: wait for a request, walk the chunks, present result
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int c_DEFAULT_WIDTH = 32;
  localparam int c_DEFAULT_CHUNK = 4;

endpackage : serial_adder_pkg
`default_nettype wire

// File: rtl/serial_adder_chunk.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adder_chunk                                                          |
// | Combinational CHUNK-bit ripple-carry adder. Besides the carry out it |
// | exposes the carry into its most significant bit so the parent can    |
// | derive signed overflow from the top chunk.                           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module adder_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_cin,
  output logic [CHUNK-1:0] o_sum,
  output logic             o_cout,
  output logic             o_cmsb
);

  // w_c[k] is the carry into bit k; w_c[CHUNK] is the carry out
  logic [CHUNK:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar k = 0; k < CHUNK; k++) begin : g_bit
    assign o_sum[k]  = i_a[k] ^ i_b[k] ^ w_c[k];
    assign w_c[k+1]  = (i_a[k] & i_b[k]) | (w_c[k] & (i_a[k] ^ i_b[k]));
  end

  assign o_cout = w_c[CHUNK];
  assign o_cmsb = w_c[CHUNK-1];

endmodule : adder_chunk
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | serial_adder                                                         |
// | Multi-cycle adder that processes CHUNK bits per clock, least         |
// | significant chunk first. Result, carry out and signed overflow are   |
// | held from the DONE pulse until the next accepted start.              |
// | Optional feature: define SERIAL_ADDER_SUB_EN to add the sub port,    |
// | which turns the operation into a - b (a + ~b + 1).                   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = c_DEFAULT_WIDTH,
  parameter int CHUNK = c_DEFAULT_CHUNK
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             overflow
);

  localparam int c_NCHUNK = WIDTH / CHUNK;
  // Keep the index at least one bit wide so the single-chunk case elaborates
  localparam int c_IDX_W  = (c_NCHUNK > 1) ? $clog2(c_NCHUNK) : 1;
  localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(c_NCHUNK - 1);

  state_t             r_state;
  logic [c_IDX_W-1:0] r_idx;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;      // already inverted when subtracting
  logic               r_carry;  // running carry between chunks
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic               r_ovf;
  logic               r_busy;
  logic               r_done;

  logic [CHUNK-1:0]   w_chunk_a;
  logic [CHUNK-1:0]   w_chunk_b;
  logic [CHUNK-1:0]   w_chunk_sum;
  logic               w_chunk_cout;
  logic               w_chunk_cmsb;
  logic [WIDTH-1:0]   w_b_eff;
  logic               w_cin_eff;

  // Subtraction is folded into operand capture so the datapath only ever adds
`ifdef SERIAL_ADDER_SUB_EN
  assign w_b_eff   = sub ? ~b : b;
  assign w_cin_eff = sub ? 1'b1 : carryin;
`else
  assign w_b_eff   = b;
  assign w_cin_eff = carryin;
`endif

  assign w_chunk_a = r_a[r_idx*CHUNK +: CHUNK];
  assign w_chunk_b = r_b[r_idx*CHUNK +: CHUNK];

  adder_chunk #(
    .CHUNK (CHUNK)
  ) u_adder_chunk (
    .i_a    (w_chunk_a),
    .i_b    (w_chunk_b),
    .i_cin  (r_carry),
    .o_sum  (w_chunk_sum),
    .o_cout (w_chunk_cout),
    .o_cmsb (w_chunk_cmsb)
  );

  // Control FSM and result registers; the final chunk also latches the flags
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= w_b_eff;
            r_carry <= w_cin_eff;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_sum[r_idx*CHUNK +: CHUNK] <= w_chunk_sum;
          r_carry                     <= w_chunk_cout;
          if (r_idx == c_LAST) begin
            // Top chunk: its carries are the carries around bit WIDTH-1
            r_cout  <= w_chunk_cout;
            r_ovf   <= w_chunk_cmsb ^ w_chunk_cout;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_idx <= r_idx + c_IDX_W'(1);
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign sum      = r_sum;
  assign carryout = r_cout;
  assign overflow = r_ovf;

endmodule : serial_adder
`default_nettype wire

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 4, giving the bits added per cycle; WIDTH SHALL be an integer multiple of CHUNK, and N = WIDTH/CHUNK.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: operation request, sampled only while busy=0.
REQ-006 The block SHALL have ports a and b, input, WIDTH bits each: operands, captured on the accepted start.
REQ-007 The block SHALL have port carryin, input, 1 bit: carry into bit 0, captured with the operands.
REQ-008 The block SHALL have port sub, input, 1 bit: subtract request; the port exists only when SERIAL_ADDER_SUB_EN is defined.
REQ-009 The block SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse when the result becomes valid.
REQ-011 The block SHALL have ports sum (output, WIDTH bits), carryout (output, 1 bit) and overflow (output, 1 bit): the result, the carry out of the MSB, and signed overflow.

Function
REQ-012 The block SHALL implement the states IDLE, RUN and DONE.
REQ-013 In IDLE or DONE, when start=1 is sampled, the block SHALL capture a, b, carryin (and sub), clear the chunk index to 0, and enter RUN.
REQ-014 In RUN, each cycle SHALL add operand chunk[i] using the running carry, write sum[i*CHUNK +: CHUNK], and increment i.
REQ-015 After chunk N-1 the block SHALL enter DONE, so that done=1 exactly N cycles after the edge that accepted start.
REQ-016 DONE SHALL last one cycle and then return to IDLE unless start=1, in which case RUN is entered directly (back-to-back operation).
REQ-017 busy SHALL equal 1 exactly in RUN, and start SHALL be ignored while busy=1.
REQ-018 sum, carryout and overflow SHALL hold their values from DONE until the next accepted start, and SHALL be held at their previous value during RUN apart from the partially written sum chunks.
REQ-019 carryout SHALL be the carry out of bit WIDTH-1.
REQ-020 overflow SHALL be (carry into bit WIDTH-1) XOR carryout.
REQ-021 CHUNK=WIDTH SHALL be legal, giving N=1 and single-cycle latency.

Reset
REQ-022 When reset=1 is sampled, the block SHALL enter IDLE and force busy=0, done=0, sum=0, carryout=0, overflow=0 and the chunk index to 0.
REQ-023 A reset applied mid-operation SHALL abort the operation with no done pulse.
REQ-024 Reset SHALL take priority over start in the same cycle.

Configuration
REQ-025 When SERIAL_ADDER_SUB_EN is defined, sub=1 captured at start SHALL compute a + ~b + 1, ignoring carryin, with carryout=1 meaning no borrow.
REQ-026 When SERIAL_ADDER_SUB_EN is undefined, the sub port and its logic SHALL be absent and the block SHALL add only.

Structure
REQ-027 The package serial_adder_pkg SHALL hold the state typedef (IDLE/RUN/DONE) and the default WIDTH and CHUNK constants.
REQ-028 The block SHALL have one sub-module, adder_chunk: a combinational CHUNK-bit ripple of full adders with carry in and out that also exposes the carry into its MSB.

Verification
REQ-029 The bench SHALL check, with WIDTH=8, CHUNK=4: 0x7F + 0x01, cin=0 -> sum=0x80, carryout=0, overflow=1, done exactly 2 cycles after start.
REQ-030 The bench SHALL check, with WIDTH=8, CHUNK=4: 0xFF + 0x01, cin=0 -> sum=0x00, carryout=1, overflow=0; and 0xFF + 0xFF, cin=1 -> sum=0xFF, carryout=1, overflow=0.
REQ-031 The bench SHALL check: start pulsed again during RUN with other operands -> ignored, the first result is returned; start held high during DONE -> the next operation runs back-to-back with no IDLE cycle.
REQ-032 The bench SHALL check: reset asserted one cycle after start -> the next cycle shows IDLE, busy=0, all outputs 0, and no done pulse.
REQ-033 The bench SHALL check, with SERIAL_ADDER_SUB_EN defined: 0x05 - 0x07 -> sum=0xFE, carryout=0, overflow=0; and 0x80 - 0x01 -> sum=0x7F, carryout=1, overflow=1.
REQ-034 The bench SHALL check, with WIDTH=32, CHUNK=32: random operands -> done 1 cycle after start and results match a+b+cin.
